operand_capture: RTL and testbench
==================================

// Module: operand_capture
// PURPOSE
//   Front-end input stage for the two-bit adder datapath on the FPGA board.
//   - Synchronises the slide switches and one active-low push-button.
//   - Debounces the button.
//   - On each clean press, latches a, b and cin from the switches and pulses valid.
//   - Registered outputs feed the adder / seven-segment stage directly, so the
//     display changes only on a deliberate key press.
// PARAMETERS
//   WIDTH            2        operand width of a and b
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles needed to accept a level (10 ms @ 50 MHz); must be >= 2
//   REPEAT_CYCLES    25000000 auto-repeat period while held (used only with OPERAND_AUTO_REPEAT_EN); must be >= 1
// PORTS
//   clk     in   1          board clock; all state changes on the rising edge
//   rst     in   1          asynchronous, active-high reset
//   sw      in   2*WIDTH+1  raw switches: sw[0]=cin, sw[WIDTH:1]=b, sw[2*WIDTH:WIDTH+1]=a
//   key_n   in   1          raw push-button, 0 = pressed
//   a       out  WIDTH      captured operand a
//   b       out  WIDTH      captured operand b
//   cin     out  1          captured carry-in
//   valid   out  1          one-cycle pulse on each capture
//   busy    out  1          high in every state except IDLE
// BEHAVIOUR
//   Reset (async, immediate):
//   - a, b, cin, valid, busy = 0.
//   - Debounce counter = 0; FSM = IDLE.
//   - key synchroniser flops = 1 (released); sw synchroniser flops = 0.
//   Synchronisers: key_n and sw each pass through 2 flops; only synced values are used.
//   FSM (counter cleared on every state change):
//   - IDLE: synced key = 0 -> ARMING.
//   - ARMING: synced key = 0 -> count++. Synced key = 1 -> IDLE (bounce).
//     When count reaches DEBOUNCE_CYCLES -> HELD, with on that same edge:
//     load a/b/cin from synced sw, and valid = 1 for exactly one cycle.
//   - HELD: synced key = 1 -> RELEASING.
//   - RELEASING: synced key = 1 -> count++. Synced key = 0 -> HELD (bounce, no new capture).
//     When count reaches DEBOUNCE_CYCLES -> IDLE.
//   Latency: valid rises on the (DEBOUNCE_CYCLES+2)th consecutive rising edge at
//     which raw key_n is sampled 0.
//   Data rules:
//   - a, b, cin change only on a capture edge; otherwise they hold.
//   - Switch changes without a press never reach the outputs.
//   - Switch value used is the synced value on the capture edge.
//   Boundary conditions:
//   - Glitch shorter than DEBOUNCE_CYCLES: no capture, outputs unchanged.
//   - Key held across reset release: treated as a new press (re-arms from IDLE).
//   - Reset mid-ARMING or mid-HELD: abort with no valid pulse; outputs clear to 0.
//   - Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1); never wraps
//     (saturating compare).
// CONFIGURATION
//   OPERAND_AUTO_REPEAT_EN defined:
//   - In HELD, a repeat counter increments every cycle.
//   - At REPEAT_CYCLES: re-capture sw, pulse valid for 1 cycle, clear the counter.
//   - Repeat counter clears on entry to HELD; RELEASING pauses it, a bounce back
//     to HELD resumes it.
//   OPERAND_AUTO_REPEAT_EN undefined:
//   - No repeat logic; exactly one valid per press; REPEAT_CYCLES ignored.
// TESTING (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, WIDTH=2)
//   1 rst=1 then release; key_n=1 -> a=b=cin=valid=busy=0 held indefinitely.
//   2 sw=5'b10_01_1, key_n=0 held -> valid=1 on 6th edge only; a=2, b=1, cin=1; busy=1.
//   3 key_n low 3 cycles then high -> no valid; a/b/cin unchanged; FSM back to IDLE.
//   4 hold pressed, change sw to 5'b11_11_0, release and press again ->
//     a/b stay 2/1 until 2nd press, then a=3, b=3, cin=0; exactly one valid per press.
//   5 during release, bounce key_n 1,0,1,0 before stable high -> no extra valid; IDLE
//     reached DEBOUNCE_CYCLES+2 edges after the last bounce.
//   6 assert rst while in HELD -> all outputs 0 asynchronously.
//     With OPERAND_AUTO_REPEAT_EN: held press gives valid every 8 cycles after the first.

Source files
------------

// File: rtl/operand_capture.sv
// ---------------------------------------------------------------------------
// operand_capture
//   Input stage for the two-bit adder datapath. It synchronises the slide
//   switches and the active-low push-button, debounces the button, and on
//   each clean press latches a, b and cin from the switches and pulses valid.
//   Because the outputs are registered, the display only changes on a
//   deliberate key press.
//
//   Optional feature macro: OPERAND_AUTO_REPEAT_EN
//     When defined, holding the button re-captures the switches and pulses
//     valid every REPEAT_CYCLES cycles. When undefined there is exactly one
//     capture per press and REPEAT_CYCLES only sizes the counter.
//
// Ports
//   clk    in   1          board clock, rising edge
//   rst    in   1          asynchronous, active-high reset
//   sw     in   2*WIDTH+1  raw switches: sw[0]=cin, sw[WIDTH:1]=b,
//                          sw[2*WIDTH:WIDTH+1]=a
//   key_n  in   1          raw push-button, 0 = pressed
//   a      out  WIDTH      captured operand a
//   b      out  WIDTH      captured operand b
//   cin    out  1          captured carry-in
//   valid  out  1          one-cycle pulse on each capture
//   busy   out  1          high whenever the debouncer is not idle
// ---------------------------------------------------------------------------
module operand_capture #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*WIDTH:0] sw,
    input  logic             key_n,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic             valid,
    output logic             busy
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                  : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    // The edge that leaves IDLE/HELD already counts as the first stable
    // sample, so the counter only has to cover the remaining samples.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             key_p0, key_p1;
    logic [2*WIDTH:0] sw_p0, sw_p1;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture;
    logic             load;

    // Stage p0 -> p1: two-flop synchronisers (button idles released)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    // Stage p1 -> control: debounce state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!key_p1) state_nxt = IDLE == IDLE ? ARMING : IDLE;
            end
            ARMING: begin
                if (key_p1) begin
                    state_nxt = IDLE;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = HELD;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (key_p1) state_nxt = RELEASING;
            end
            RELEASING: begin
                if (!key_p1) begin
                    state_nxt = HELD;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Any state change restarts the stability count.
        if (state_nxt != state) cnt_nxt = '0;
    end

`ifdef OPERAND_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep, rep_nxt;
    logic             rep_fire;

    // Repeat counter only advances while HELD stays HELD, so a release
    // bounce pauses it and the return to HELD resumes from where it was.
    always_comb begin
        rep_nxt  = rep;
        rep_fire = 1'b0;
        if (capture) begin
            rep_nxt = '0;
        end else if (state == HELD && state_nxt == HELD) begin
            if (rep >= REP_LAST) begin
                rep_fire = 1'b1;
                rep_nxt  = '0;
            end else begin
                rep_nxt = rep + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep <= '0;
        else     rep <= rep_nxt;
    end

    assign load = capture | rep_fire;
`else
    assign load = capture;
`endif

    // Stage p1 -> outputs: operand registers and valid strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            cin   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                a   <= sw_p1[2*WIDTH:WIDTH+1];
                b   <= sw_p1[WIDTH:1];
                cin <= sw_p1[0];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_operand_capture.sv
module tb_operand_capture;

    localparam int W  = 2;
    localparam int DB = 4;
    localparam int RP = 8;

    logic           clk;
    logic           rst;
    logic [2*W:0]   sw;
    logic           key_n;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic           valid;
    logic           busy;

    int checks = 0;
    int errors = 0;

    operand_capture #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .key_n(key_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .valid(valid),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: delay line for the raw inputs, a debounced level,
    // and the length of the current run of samples disagreeing with it.
    logic       mk_s1, mk_s2;
    logic [4:0] msw_s1, msw_s2;
    bit         m_pressed;
    int         m_run;
    int         m_rep;
    logic       m_valid;
    logic [1:0] m_a, m_b;
    logic       m_cin;

    task automatic model_reset();
        mk_s1 = 1'b1; mk_s2 = 1'b1;
        msw_s1 = '0;  msw_s2 = '0;
        m_pressed = 0; m_run = 0; m_rep = 0;
        m_valid = 0; m_a = '0; m_b = '0; m_cin = 0;
    endtask

    task automatic model_edge(input logic kraw, input logic [4:0] swraw);
        bit         seen_pressed;
        logic [4:0] seen_sw;
        bit         load;
        seen_pressed = (mk_s2 == 1'b0);
        seen_sw      = msw_s2;
        mk_s2 = mk_s1;  mk_s1 = kraw;
        msw_s2 = msw_s1; msw_s1 = swraw;
        load = 0;
        if (seen_pressed != m_pressed) begin
            if (m_run + 1 == DB) begin
                m_pressed = seen_pressed;
                m_run = 0;
                if (m_pressed) begin
                    load = 1;
                    m_rep = 0;
                end
            end else begin
                m_run++;
            end
        end else begin
`ifdef OPERAND_AUTO_REPEAT_EN
            if (m_pressed && m_run == 0) begin
                if (m_rep + 1 == RP) begin
                    load = 1;
                    m_rep = 0;
                end else begin
                    m_rep++;
                end
            end
`endif
            m_run = 0;
        end
        m_valid = load;
        if (load) begin
            m_a = seen_sw[4:3]; m_b = seen_sw[2:1]; m_cin = seen_sw[0];
        end
    endtask

    function automatic logic [6:0] model_out();
        logic mb;
        mb = m_pressed || (m_run > 0);
        return {m_valid, mb, m_a, m_b, m_cin};
    endfunction

    function automatic logic [6:0] dut_out();
        return {valid, busy, a, b, cin};
    endfunction

    task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got valid/busy/a/b/cin=%b required %b", name, got, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic step(input logic k, input logic [4:0] s);
        key_n = k;
        sw    = s;
        @(posedge clk);
        model_edge(k, s);
        @(negedge clk);
    endtask

    task automatic step_chk(input logic k, input logic [4:0] s, input string name);
        step(k, s);
        cmp(name, dut_out(), model_out());
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b1;
        #1;
        model_reset();
        cmp(name, dut_out(), 7'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       key;
        logic [4:0] sw;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic k, input logic [4:0] s, input logic v,
                       input logic bz, input logic [4:0] abc);
        vec_t r;
        r.key = k; r.sw = s; r.exp = {v, bz, abc};
        tbl.push_back(r);
    endtask

    initial begin
        int         nval;
        int         n;
        logic [4:0] rsw;
        logic       lvl;
        int         len;

        rst = 1'b1; key_n = 1'b1; sw = '0;
        model_reset();
        @(negedge clk);
        cmp("reset_state", dut_out(), 7'b0);
        @(negedge clk);
        rst = 1'b0;

        // idle with switches set but no press
        for (int i = 0; i < 4; i++) add(1, 5'b10_01_1, 0, 0, 5'b00000);
        // clean press: valid on the sixth low edge
        for (int i = 0; i < 2; i++) add(0, 5'b10_01_1, 0, 0, 5'b00000);
        for (int i = 0; i < 3; i++) add(0, 5'b10_01_1, 0, 1, 5'b00000);
        add(0, 5'b10_01_1, 1, 1, 5'b10_01_1);
        for (int i = 0; i < 2; i++) add(0, 5'b10_01_1, 0, 1, 5'b10_01_1);
        // clean release
        for (int i = 0; i < 5; i++) add(1, 5'b10_01_1, 0, 1, 5'b10_01_1);
        add(1, 5'b10_01_1, 0, 0, 5'b10_01_1);
        // three-cycle glitch with different switches: no capture
        for (int i = 0; i < 2; i++) add(0, 5'b01_10_0, 0, 0, 5'b10_01_1);
        add(0, 5'b01_10_0, 0, 1, 5'b10_01_1);
        for (int i = 0; i < 2; i++) add(1, 5'b01_10_0, 0, 1, 5'b10_01_1);
        for (int i = 0; i < 2; i++) add(1, 5'b01_10_0, 0, 0, 5'b10_01_1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].key, tbl[i].sw);
            cmp($sformatf("tbl[%0d]", i), dut_out(), tbl[i].exp);
        end

        // switches changed while held only take effect on the next press
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            step_chk(0, 5'b10_01_1, "t4_press1");
            if (valid) nval++;
        end
        cmp_int("t4_valids_press1", nval, 1);
        for (int i = 0; i < 2; i++) begin
            step_chk(0, 5'b11_11_0, "t4_hold");
            cmp("t4_hold_operands", {2'b00, a, b, cin}, {2'b00, 5'b10_01_1});
        end
        for (int i = 0; i < 6; i++) step_chk(1, 5'b11_11_0, "t4_release");
        cmp("t4_idle", {1'b0, busy, 5'b0}, 7'b0);
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            step_chk(0, 5'b11_11_0, "t4_press2");
            if (valid) nval++;
        end
        cmp_int("t4_valids_press2", nval, 1);
        cmp("t4_new_operands", {2'b00, a, b, cin}, {2'b00, 5'b11_11_0});

        // release bounce: no extra capture, IDLE six edges after last bounce
        nval = 0;
        step_chk(1, 5'b00_00_1, "t5_bounce"); if (valid) nval++;
        step_chk(0, 5'b00_00_1, "t5_bounce"); if (valid) nval++;
        step_chk(1, 5'b00_00_1, "t5_bounce"); if (valid) nval++;
        step_chk(0, 5'b00_00_1, "t5_bounce"); if (valid) nval++;
        n = 0;
        do begin
            step_chk(1, 5'b00_00_1, "t5_release");
            if (valid) nval++;
            n++;
        end while (busy && n < 20);
        cmp_int("t5_idle_edges", n, DB + 2);
        cmp_int("t5_extra_valids", nval, 0);
        cmp("t5_operands_kept", {2'b00, a, b, cin}, {2'b00, 5'b11_11_0});

        // reset while HELD, then key held across reset release
        for (int i = 0; i < 8; i++) step_chk(0, 5'b01_01_1, "t6_press");
        cmp("t6_captured", {2'b00, a, b, cin}, {2'b00, 5'b01_01_1});
        reset_pulse("t6_async_clear_held");
        n = 0;
        do begin
            step_chk(0, 5'b01_10_1, "t6_rearm");
            n++;
        end while (!valid && n < 20);
        cmp_int("t6_rearm_latency", n, DB + 2);
        cmp("t6_rearm_operands", {2'b00, a, b, cin}, {2'b00, 5'b01_10_1});
        for (int i = 0; i < 6; i++) step_chk(1, 5'b01_10_1, "t6_release");

        // reset mid-ARMING aborts without a pulse
        for (int i = 0; i < 4; i++) step_chk(0, 5'b11_00_1, "t6_arming");
        reset_pulse("t6_async_clear_arming");
        nval = 0;
        for (int i = 0; i < 6; i++) begin
            step_chk(1, 5'b11_00_1, "t6_after_abort");
            if (valid) nval++;
        end
        cmp_int("t6_abort_valids", nval, 0);

`ifdef OPERAND_AUTO_REPEAT_EN
        begin
            int hits[$];
            for (int i = 1; i <= 24; i++) begin
                step_chk(0, 5'b10_10_0, "rep_hold");
                if (valid) hits.push_back(i);
            end
            cmp_int("rep_count", hits.size(), 3);
            if (hits.size() == 3) begin
                cmp_int("rep_first", hits[0], DB + 2);
                cmp_int("rep_gap1", hits[1] - hits[0], RP);
                cmp_int("rep_gap2", hits[2] - hits[1], RP);
            end
            for (int i = 0; i < 8; i++) step_chk(1, 5'b10_10_0, "rep_release");
        end
`endif

        // randomized runs of key levels with changing switches
        rsw = 5'($urandom);
        for (int r = 0; r < 60; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) rsw = 5'($urandom);
                step_chk(lvl, rsw, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
